// File: rtl/c2h_tlp_splitter.sv
// Splits one C2H descriptor plus its AXI4-Stream frame into PCIe write-payload segments.
// Optional `C2H_SPLIT_4K_EN: also keep every segment inside one 4 KB address page.
module c2h_tlp_splitter #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned MAX_PAYLOAD = 256,
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned LEN_WIDTH   = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_desc_addr,
  input  logic [LEN_WIDTH-1:0]  s_desc_len,
  input  logic                  s_desc_valid,
  output logic                  s_desc_ready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ADDR_WIDTH-1:0] m_seg_addr,
  output logic [12:0]           m_seg_len,
  output logic                  m_seg_last,
  output logic                  status_len_err,
  output logic                  busy
);

  localparam int unsigned BeatShift = $clog2(KEEP_WIDTH);
  localparam int unsigned EntryW    = DATA_WIDTH + KEEP_WIDTH + 1 + ADDR_WIDTH + 13 + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StXfer, StDrain} state_e;

  function automatic logic [12:0] calc_seg_len(input logic [12:0]          room,
                                               input logic [LEN_WIDTH-1:0] rem);
    logic [12:0] len;
    len = 13'(MAX_PAYLOAD);
    if (rem < LEN_WIDTH'(MAX_PAYLOAD)) len = rem[12:0];
    if (room < len) len = room;
    return len;
  endfunction

  function automatic logic [12:0] calc_beats(input logic [12:0] len);
    return 13'(({1'b0, len} + 14'(KEEP_WIDTH - 1)) >> BeatShift);
  endfunction

  state_e                 state_q, state_d;
  logic                   init_q;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d, addr_adv;
  logic [LEN_WIDTH-1:0]   rem_q, rem_d, rem_adv, rem_lanes;
  logic [12:0]            seg_len_q, seg_len_d, cur_len, nxt_len;
  logic [12:0]            room_cur, room_nxt;
  logic                   seg_last_q, seg_last_d;
  logic [12:0]            beat_cnt_q, beat_cnt_d;
  logic                   err_q, err_d;
  logic                   push, pop, fifo_space;
  logic                   out_last;
  logic [KEEP_WIDTH-1:0]  out_keep, tail_keep;
  logic [EntryW-1:0]      fifo_q [2];
  logic                   wr_ptr_q, rd_ptr_q;
  logic [1:0]             cnt_q;
  logic                   unused_tkeep;

  // Output keep is rebuilt from the length, so the incoming keep is deliberately ignored.
  assign unused_tkeep = ^s_axis_tkeep;

  assign addr_adv = addr_q + ADDR_WIDTH'(seg_len_q);
  assign rem_adv  = rem_q - LEN_WIDTH'(seg_len_q);

`ifdef C2H_SPLIT_4K_EN
  assign room_cur = 13'd4096 - {1'b0, addr_q[11:0]};
  assign room_nxt = 13'd4096 - {1'b0, addr_adv[11:0]};
`else
  assign room_cur = 13'd4096;
  assign room_nxt = 13'd4096;
`endif

  assign cur_len   = calc_seg_len(room_cur, rem_q);
  assign nxt_len   = calc_seg_len(room_nxt, rem_adv);
  assign rem_lanes = rem_q & LEN_WIDTH'(KEEP_WIDTH - 1);
  assign tail_keep = (rem_lanes == '0) ? '1 : (KEEP_WIDTH'(1) << rem_lanes) - KEEP_WIDTH'(1);

  // Ready is a function of registered occupancy only, isolating upstream from m_axis_tready.
  assign fifo_space = (cnt_q != 2'd2);
  assign pop        = (cnt_q != 2'd0) && m_axis_tready;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    seg_len_d     = seg_len_q;
    seg_last_d    = seg_last_q;
    beat_cnt_d    = beat_cnt_q;
    err_d         = 1'b0;
    s_desc_ready  = 1'b0;
    s_axis_tready = 1'b0;
    push          = 1'b0;
    out_last      = 1'b0;
    out_keep      = '1;
    unique case (state_q)
      StIdle: begin
        s_desc_ready = init_q;
        if (s_desc_valid && init_q) begin
          addr_d  = s_desc_addr & ~ADDR_WIDTH'(KEEP_WIDTH - 1);
          rem_d   = (s_desc_len == '0) ? LEN_WIDTH'(1) : s_desc_len;
          state_d = StCalc;
        end
      end
      StCalc: begin
        seg_len_d  = cur_len;
        seg_last_d = (LEN_WIDTH'(cur_len) == rem_q);
        beat_cnt_d = calc_beats(cur_len);
        state_d    = StXfer;
      end
      StXfer: begin
        s_axis_tready = fifo_space;
        if (seg_last_q && beat_cnt_q == 13'd1) out_keep = tail_keep;
        if (s_axis_tvalid && fifo_space) begin
          push = 1'b1;
          if (beat_cnt_q == 13'd1) begin
            out_last = 1'b1;
            addr_d   = addr_adv;
            rem_d    = rem_adv;
            if (seg_last_q) begin
              if (s_axis_tlast) begin
                state_d = StIdle;
              end else begin
                err_d   = 1'b1;
                state_d = StDrain;
              end
            end else if (s_axis_tlast) begin
              err_d   = 1'b1;
              state_d = StIdle;
            end else begin
              // Next segment starts on the following beat with no bubble.
              seg_len_d  = nxt_len;
              seg_last_d = (LEN_WIDTH'(nxt_len) == rem_adv);
              beat_cnt_d = calc_beats(nxt_len);
            end
          end else begin
            beat_cnt_d = beat_cnt_q - 13'd1;
            if (s_axis_tlast) begin
              out_last = 1'b1;
              err_d    = 1'b1;
              state_d  = StIdle;
            end
          end
        end
      end
      StDrain: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      init_q     <= 1'b0;
      addr_q     <= '0;
      rem_q      <= '0;
      seg_len_q  <= '0;
      seg_last_q <= 1'b0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_q     <= 1'b1;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      seg_len_q  <= seg_len_d;
      seg_last_q <= seg_last_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= {s_axis_tdata, out_keep, out_last, addr_q, seg_len_q, seg_last_q};
      end
      wr_ptr_q <= wr_ptr_q ^ push;
      rd_ptr_q <= rd_ptr_q ^ pop;
      cnt_q    <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_seg_addr, m_seg_len, m_seg_last} =
      fifo_q[rd_ptr_q];
  assign m_axis_tvalid  = (cnt_q != 2'd0);
  assign status_len_err = err_q;
  assign busy           = (state_q != StIdle) || (cnt_q != 2'd0);

endmodule

// File: tb/tb_c2h_tlp_splitter.sv
// Bench for c2h_tlp_splitter: vector table run against a segment-walking reference model,
// plus directed latency and mid-transfer reset sequences.
module tb_c2h_tlp_splitter;

  localparam int MPS = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] s_desc_addr;
  logic [23:0] s_desc_len;
  logic        s_desc_valid;
  logic        s_desc_ready;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [63:0] m_seg_addr;
  logic [12:0] m_seg_len;
  logic        m_seg_last;
  logic        status_len_err;
  logic        busy;

  c2h_tlp_splitter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_desc_addr   (s_desc_addr),
    .s_desc_len    (s_desc_len),
    .s_desc_valid  (s_desc_valid),
    .s_desc_ready  (s_desc_ready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_seg_addr    (m_seg_addr),
    .m_seg_len     (m_seg_len),
    .m_seg_last    (m_seg_last),
    .status_len_err(status_len_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          len;
    int          nb;
    int          in_pct;
    int          out_pct;
    int          exp_segs;
    int          exp_beats;
    int          exp_err;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [63:0] addr;
    logic [12:0] len;
    logic        seg_last;
  } exp_beat_t;

  vec_t        vecs[8];
  exp_beat_t   expq[$];
  logic [63:0] din[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic logic [159:0] pack_beat(input exp_beat_t e);
    return {9'b0, e.data, e.keep, e.last, e.addr, e.len, e.seg_last};
  endfunction

  // Walk the transfer segment by segment: min(MPS, remaining[, room to 4 KB page end]).
  task automatic build_model(input logic [63:0] a0, input int len, input int nb,
                             output int err_exp);
    logic [63:0] a;
    int          r, ib, sl, nbt, k;
    bit          done, seg_end, last_in, fin;
    exp_beat_t   e;
    a = a0 & ~64'h7;
    r = (len == 0) ? 1 : len;
    ib = 0;
    err_exp = 0;
    done = 0;
    expq.delete();
    while (r > 0 && !done) begin
      sl = (r < MPS) ? r : MPS;
`ifdef C2H_SPLIT_4K_EN
      if (4096 - int'(a[11:0]) < sl) sl = 4096 - int'(a[11:0]);
`endif
      nbt = (sl + 7) / 8;
      k = 0;
      while (k < nbt && !done) begin
        seg_end = (k == nbt - 1);
        last_in = (ib == nb - 1);
        fin     = seg_end && (sl == r);
        e.data  = din[ib];
        e.keep  = (fin && (r % 8) != 0) ? 8'((1 << (r % 8)) - 1) : 8'hFF;
        e.last  = seg_end || last_in;
        e.addr  = a;
        e.len   = 13'(sl);
        e.seg_last = (sl == r);
        expq.push_back(e);
        if (last_in != fin) begin
          err_exp = 1;
          done = 1;
        end
        ib++;
        k++;
      end
      a += 64'(sl);
      r -= sl;
    end
  endtask

  task automatic send_desc(input logic [63:0] a, input int len);
    int w;
    @(negedge clk);
    s_desc_addr  = a;
    s_desc_len   = 24'(len);
    s_desc_valid = 1'b1;
    #1;
    w = 0;
    while (!s_desc_ready && w < 200) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (w >= 200) begin
      n_cmp++;
      n_fail++;
      $display("FAIL desc_timeout: s_desc_ready stayed 0, required 1");
    end
    @(posedge clk);
    #1;
    s_desc_valid = 1'b0;
  endtask

  task automatic run_vec(input int i);
    int err_exp, in_idx, cyc, err_cnt, segs, beats;
    exp_beat_t e;
    logic [159:0] got;
    din.delete();
    for (int k = 0; k < vecs[i].nb; k++) din.push_back({$urandom, $urandom});
    build_model(vecs[i].addr, vecs[i].len, vecs[i].nb, err_exp);
    send_desc(vecs[i].addr, vecs[i].len);
    in_idx = 0; cyc = 0; err_cnt = 0; segs = 0; beats = 0;
    while ((in_idx < vecs[i].nb || expq.size() > 0) && cyc < 20000) begin
      @(negedge clk);
      if (in_idx < vecs[i].nb) begin
        s_axis_tvalid = ($urandom_range(99) < vecs[i].in_pct);
        s_axis_tdata  = din[in_idx];
        s_axis_tlast  = (in_idx == vecs[i].nb - 1);
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
      end
      s_axis_tkeep  = 8'($urandom);
      m_axis_tready = ($urandom_range(99) < vecs[i].out_pct);
      #1;
      if (status_len_err) err_cnt++;
      if (s_axis_tvalid && s_axis_tready) in_idx++;
      if (m_axis_tvalid && m_axis_tready) begin
        beats++;
        if (m_axis_tlast) segs++;
        got = {9'b0, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_seg_addr, m_seg_len,
               m_seg_last};
        if (expq.size() == 0) begin
          check($sformatf("v%0d extra_beat", i), got, 160'd0);
        end else begin
          e = expq.pop_front();
          check($sformatf("v%0d beat%0d", i, beats), got, pack_beat(e));
        end
      end
      cyc++;
    end
    if (cyc >= 20000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL v%0d timeout: %0d input beats taken, %0d outputs still expected",
               i, in_idx, expq.size());
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b1;
      #1;
      if (status_len_err) err_cnt++;
      if (m_axis_tvalid) beats++;
    end
    check($sformatf("v%0d segs", i), 160'(segs), 160'(vecs[i].exp_segs));
    check($sformatf("v%0d beats", i), 160'(beats), 160'(vecs[i].exp_beats));
    check($sformatf("v%0d len_err", i), 160'(err_cnt), 160'(vecs[i].exp_err));
    check($sformatf("v%0d model_err", i), 160'(err_cnt), 160'(err_exp));
    check($sformatf("v%0d idle", i), {158'd0, busy, s_desc_ready}, 160'b01);
  endtask

  initial begin
    logic [63:0] d0;
    rst_n = 1'b0;
    s_desc_addr = '0; s_desc_len = '0; s_desc_valid = 1'b0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b0;

    //            addr        len   nb  in  out segs beats err
    vecs[0] = '{64'h1000,    512,  64, 100, 100, 2,  64, 0};
`ifdef C2H_SPLIT_4K_EN
    vecs[1] = '{64'h0FC0,    256,  32, 100, 100, 2,  32, 0};
    vecs[7] = '{64'h7F80,   1000, 125,  70,  70, 5, 125, 0};
`else
    vecs[1] = '{64'h0FC0,    256,  32, 100, 100, 1,  32, 0};
    vecs[7] = '{64'h7F80,   1000, 125,  70,  70, 4, 125, 0};
`endif
    vecs[2] = '{64'h2000,     20,   3, 100, 100, 1,   3, 0};
    vecs[3] = '{64'h3000,     64,   4, 100, 100, 1,   4, 1};
    vecs[4] = '{64'h4000,     16,   5, 100, 100, 1,   2, 1};
    vecs[5] = '{64'h10000,  4096, 512,  90,  50, 16, 512, 0};
    vecs[6] = '{64'h5003,      0,   1, 100, 100, 1,   1, 0};

    // Reset state
    #12;
    check("rst_desc_ready", 160'(s_desc_ready), 160'd0);
    check("rst_valids", {157'd0, m_axis_tvalid, s_axis_tready, m_axis_tlast}, 160'd0);
    check("rst_status", {158'd0, status_len_err, busy}, 160'd0);
    check("rst_sideband", {82'd0, m_seg_addr, m_seg_len, m_seg_last}, 160'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_desc_ready", 160'(s_desc_ready), 160'd1);

    // Latency: descriptor at T, tready at T+2, first output at T+3
    d0 = {$urandom, $urandom};
    @(negedge clk);
    s_desc_addr = 64'h8000; s_desc_len = 24'd8; s_desc_valid = 1'b1;
    s_axis_tdata = d0; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1; m_axis_tready = 1'b0;
    @(posedge clk);
    #1;
    s_desc_valid = 1'b0;
    @(negedge clk);
    #1;
    check("lat_t1", {157'd0, s_axis_tready, m_axis_tvalid, busy}, 160'b001);
    @(negedge clk);
    #1;
    check("lat_t2", {158'd0, s_axis_tready, m_axis_tvalid}, 160'b10);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    #1;
    check("lat_t3_beat", {9'b0, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                          m_seg_addr, m_seg_len, m_seg_last},
          {9'b0, 1'b1, d0, 8'hFF, 1'b1, 64'h8000, 13'd8, 1'b1});
    @(negedge clk);
    #1;
    check("lat_hold", {86'd0, m_axis_tvalid, m_axis_tdata, m_axis_tlast}, {86'd0, 1'b1, d0, 1'b1});
    m_axis_tready = 1'b1;
    @(negedge clk);
    #1;
    check("lat_done", {157'd0, m_axis_tvalid, busy, s_desc_ready}, 160'b001);

    for (int i = 0; i < 8; i++) run_vec(i);

    // Reset in the middle of a segment with the skid buffer full
    send_desc(64'h1000, 512);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      s_axis_tvalid = 1'b1; s_axis_tdata = {$urandom, $urandom}; s_axis_tlast = 1'b0;
      m_axis_tready = 1'b0;
    end
    #1;
    check("mid_buffered", {158'd0, m_axis_tvalid, busy}, 160'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valids", {156'd0, m_axis_tvalid, s_axis_tready, s_desc_ready, busy}, 160'd0);
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_desc_ready", 160'(s_desc_ready), 160'd1);
    run_vec(2);
    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/c2h_tlp_splitter.md
# c2h_tlp_splitter

Splits one C2H DMA transfer, defined by a descriptor (start address, byte length) plus the matching AXI4-Stream frame, into PCIe write-payload segments. Each segment is no longer than MAX_PAYLOAD bytes and never crosses a 4 KB address boundary. The block sits directly downstream of the C2H stream FIFO/width adapter and feeds the memory-write TLP header generator. Every output beat carries its segment's address and length sideband, so the TLP generator can build headers without buffering.

## Interface
Parameters:
- DATA_WIDTH, 64: stream width in bits; must be a multiple of 8.
- KEEP_WIDTH, DATA_WIDTH/8: byte lanes per beat (BEAT_BYTES).
- MAX_PAYLOAD, 256: maximum segment size in bytes; power of 2, BEAT_BYTES..4096.
- ADDR_WIDTH, 64: host address width.
- LEN_WIDTH, 24: descriptor length width in bytes.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_desc_addr  in  ADDR_WIDTH  transfer start address; low log2(BEAT_BYTES) bits are treated as zero.
- s_desc_len  in  LEN_WIDTH  transfer length in bytes; 0 is illegal and is treated as 1.
- s_desc_valid / s_desc_ready  in/out  1  descriptor handshake.
- s_axis_tdata  in  DATA_WIDTH  payload data.
- s_axis_tkeep  in  KEEP_WIDTH  ignored; output keep is derived from the length.
- s_axis_tvalid / s_axis_tready / s_axis_tlast  in/out/in  1  input stream.
- m_axis_tdata / m_axis_tkeep  out  DATA_WIDTH/KEEP_WIDTH  segment payload.
- m_axis_tvalid / m_axis_tready / m_axis_tlast  out/in/out  1  output stream; tlast marks the segment end.
- m_seg_addr  out  ADDR_WIDTH  segment start address; stable for the whole segment.
- m_seg_len  out  13  segment length in bytes (1..4096).
- m_seg_last  out  1  this segment is the final one of the descriptor.
- status_len_err  out  1  one-cycle pulse on a frame/length mismatch.
- busy  out  1  high from descriptor accept until the final output beat is accepted.

## Operation
- FSM states: IDLE, CALC, XFER, DRAIN.
- IDLE:
  - s_desc_ready=1.
  - On handshake: latch addr and remaining=len, then go to CALC.
- CALC (1 cycle):
  - seg_len = min(MAX_PAYLOAD, remaining, 4096 - addr[11:0]).
  - Load the beat counter with ceil(seg_len/BEAT_BYTES).
  - Go to XFER.
- XFER:
  - s_axis_tready follows the output skid buffer's space.
  - Each accepted beat is forwarded with the current segment sideband.
  - m_axis_tkeep is all ones, except on the final beat of the descriptor: low (remaining mod BEAT_BYTES) lanes set, or all ones when that value is 0.
- Segment end (beat counter reaches 1 on an accepted beat):
  - Output tlast=1.
  - addr += seg_len; remaining -= seg_len.
  - If remaining becomes 0: m_seg_last was 1 for this segment. If input tlast=1 on that beat, go to IDLE. If input tlast=0, pulse status_len_err and go to DRAIN.
  - Otherwise compute the next seg_len combinationally in the same cycle and stay in XFER. There is no bubble between segments.
- Early input tlast (remaining not exhausted):
  - Forward the beat with output tlast=1.
  - Pulse status_len_err and go to IDLE.
  - The sideband of that beat keeps its original seg_len.
- DRAIN:
  - s_axis_tready=1; beats are discarded and nothing is output.
  - On an accepted input tlast, go to IDLE.
- Arithmetic:
  - addr is a full ADDR_WIDTH add with no wrap handling.
  - remaining is LEN_WIDTH unsigned and never underflows, because seg_len ≤ remaining.

## Timing
- Reset values: s_desc_ready=0 while rst_n is low and 1 from the first clock after release. m_axis_tvalid=0, s_axis_tready=0, m_axis_tlast=0, status_len_err=0, busy=0, and all sideband outputs=0.
- Descriptor accepted at cycle T:
  - CALC at T+1.
  - s_axis_tready can first be high at T+2.
  - The first m_axis_tvalid is earliest at T+3.
- Output is registered with a 2-entry skid buffer:
  - Latency is 1 cycle.
  - Sustained throughput is 1 beat/cycle.
  - m_axis_tready has no combinational path to s_axis_tready.
- Output handshake: m_axis_tvalid and all output fields are held stable until m_axis_tready=1.
- Descriptor overlap: a new descriptor is accepted only in IDLE. Back-to-back transfers therefore have a 2-cycle descriptor-to-data gap.
- Reset mid-transfer: the FSM goes to IDLE immediately and buffered beats are dropped. Recovering the upstream frame is the upstream's responsibility.

## Configuration
- C2H_SPLIT_4K_EN defined: the 4 KB boundary term is included in seg_len.
- C2H_SPLIT_4K_EN undefined: seg_len = min(MAX_PAYLOAD, remaining), and the 12-bit boundary logic is removed. Use only when the host guarantees MAX_PAYLOAD-aligned buffers.

## Test plan
- Two full segments: desc addr 0x1000, len 512, MAX_PAYLOAD 256, 64-bit bus, 64 input beats ending in tlast. Expect 2 segments of 32 beats at 0x1000 and 0x1100, each len 256, tlast on beats 32 and 64, m_seg_last=1 only on the second, no status_len_err.
- 4 KB crossing: addr 0x0FC0, len 256. With C2H_SPLIT_4K_EN: segments len 64 @0x0FC0 (8 beats) and len 192 @0x1000 (24 beats). Without the macro: one segment, len 256.
- Short transfer: len 20, 3 beats. Expect one segment of len 20, keep 0xFF, 0xFF, 0x0F, tlast on beat 3.
- Early tlast: len 64 with input tlast on beat 4. Expect output tlast on beat 4, a status_len_err pulse, and return to IDLE (s_desc_ready=1 next cycle).
- Long frame: len 16 with an input tlast on beat 5. Expect 2 output beats, then a status_len_err pulse and beats 3..5 discarded.
- Backpressure and reset:
  - Random 50% m_axis_tready over a 4096-byte transfer: data in order with no loss or duplication.
  - rst_n asserted mid-segment: all valids are low within the same cycle, s_desc_ready=1 after release, and the next descriptor processes correctly.
